// File: rtl/mac_accum_8x16.sv
// Block accumulator: sums a programmable number of unsigned products from the
// upstream multiplier and presents a saturating result with a valid/ready handshake.
module mac_accum_8x16 #(
  parameter int PW = 8,
  parameter int AW = 16,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic [PW-1:0] prod_in,
  input  logic          prod_valid,
  output logic          prod_ready,
  output logic [AW-1:0] sum_out,
  output logic          sum_valid,
  input  logic          sum_ready,
  output logic          busy,
  output logic          ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] acc, acc_nxt;
  logic [CW:0]   remain, remain_nxt;
  logic [AW-1:0] sum_nxt;
  logic          sum_valid_nxt;
  logic          ovf_nxt;

  logic          xfer;
  logic [AW:0]   add_wide;
  logic          sat;
  logic [AW-1:0] acc_add;
  logic [CW:0]   len_load;

  assign prod_ready = (state == ACCUM);
  assign busy       = (state != IDLE);
  assign xfer       = prod_valid && prod_ready;

  // One extra bit catches the carry that signals saturation.
  assign add_wide = {1'b0, acc} + (AW+1)'(prod_in);
  assign sat      = add_wide[AW];
  assign acc_add  = sat ? {AW{1'b1}} : add_wide[AW-1:0];

  // A zero length field encodes the maximum block of 2^CW products.
  assign len_load = (len == '0) ? {1'b1, {CW{1'b0}}} : {1'b0, len};

  // NOTE: every target gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    remain_nxt    = remain;
    sum_nxt       = sum_out;
    sum_valid_nxt = sum_valid;
    ovf_nxt       = ovf;

    unique case (state)
      IDLE: begin
        if (start) begin
          acc_nxt    = '0;
          ovf_nxt    = 1'b0;
          remain_nxt = len_load;
          state_nxt  = ACCUM;
        end
      end

      ACCUM: begin
        if (xfer) begin
          acc_nxt    = acc_add;
          ovf_nxt    = ovf | sat;
          remain_nxt = remain - (CW+1)'(1);
          if (remain == (CW+1)'(1)) begin
            sum_nxt       = acc_add;
            sum_valid_nxt = 1'b1;
            state_nxt     = HOLD;
          end
        end
      end

      HOLD: begin
        if (sum_ready) begin
          sum_valid_nxt = 1'b0;
          // Consuming the result and starting the next block can share a cycle.
          if (start) begin
            acc_nxt    = '0;
            ovf_nxt    = 1'b0;
            remain_nxt = len_load;
            state_nxt  = ACCUM;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      remain    <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      remain    <= remain_nxt;
      sum_out   <= sum_nxt;
      sum_valid <= sum_valid_nxt;
      ovf       <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_mac_accum_8x16.sv
// Directed bench for mac_accum_8x16: a default 16-bit instance and an 8-bit
// accumulator instance share one stimulus stream so saturation is exercised.
module tb_mac_accum_8x16;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] len;
  logic [7:0] prod_in;
  logic       prod_valid;
  logic       sum_ready;

  logic        rdy16, sv16, busy16, ovf16;
  logic [15:0] sum16;
  logic        rdy8, sv8, busy8, ovf8;
  logic [7:0]  sum8;

  int total = 0;
  int bad   = 0;

  mac_accum_8x16 dut16 (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(rdy16),
    .sum_out(sum16), .sum_valid(sv16), .sum_ready(sum_ready),
    .busy(busy16), .ovf(ovf16)
  );

  mac_accum_8x16 #(.PW(8), .AW(8), .CW(4)) dut8 (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(rdy8),
    .sum_out(sum8), .sum_valid(sv8), .sum_ready(sum_ready),
    .busy(busy8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled and inputs driven 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one product and hold it until the 16-bit instance accepts it.
  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    prod_valid = 1'b1;
    prod_in    = v;
    while (!rdy16 && n < 20) begin
      step();
      n++;
    end
    if (n == 20) chk("send_timeout", 32'(n), 32'(0));
    step();
    prod_valid = 1'b0;
  endtask

  initial begin
    int xfers;
    int cyc;

    reset = 1'b0; start = 1'b0; len = 4'd0;
    prod_in = 8'd0; prod_valid = 1'b0; sum_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_sum_valid", 32'(sv16), 0);
    chk("rst_sum_out",   32'(sum16), 0);
    chk("rst_ovf",       32'(ovf16), 0);
    chk("rst_prod_ready",32'(rdy16), 0);
    chk("rst_busy",      32'(busy16), 0);

    // Block of 3: 15 + 30 + 225 = 270; the 8-bit instance saturates.
    reset = 1'b1;
    sum_ready = 1'b1;
    start = 1'b1; len = 4'd3;
    step();
    start = 1'b0;
    chk("b3_busy",  32'(busy16), 1);
    chk("b3_ready", 32'(rdy16), 1);
    send(8'd15);
    send(8'd30);
    chk("b3_no_early_valid", 32'(sv16), 0);
    send(8'd225);
    chk("b3_sum_valid", 32'(sv16), 1);
    chk("b3_sum_out",   32'(sum16), 270);
    chk("b3_ovf",       32'(ovf16), 0);
    chk("b3_ready_hold",32'(rdy16), 0);
    chk("b3_sum8_sat",  32'(sum8), 255);
    chk("b3_ovf8",      32'(ovf8), 1);
    step();
    chk("b3_idle_busy",     32'(busy16), 0);
    chk("b3_idle_valid",    32'(sv16), 0);
    chk("b3_sum_retained",  32'(sum16), 270);

    // Maximum block (len=0 -> 16) with prod_valid toggling every cycle.
    start = 1'b1; len = 4'd0;
    step();
    start = 1'b0;
    xfers = 0;
    cyc   = 0;
    prod_in = 8'd255;
    prod_valid = 1'b0;
    while (!sv16 && cyc < 40) begin
      prod_valid = ~prod_valid;
      if (prod_valid) xfers++;
      step();
      cyc++;
    end
    prod_valid = 1'b0;
    chk("b16_timeout", 32'(sv16), 1);
    chk("b16_xfers",   32'(xfers), 16);
    chk("b16_sum_out", 32'(sum16), 4080);
    chk("b16_ovf",     32'(ovf16), 0);
    chk("b16_sum8",    32'(sum8), 255);
    step();
    chk("b16_idle", 32'(busy16), 0);

    // 200 + 100: 300 on the wide instance, saturated 255 with ovf on the narrow one.
    start = 1'b1; len = 4'd2;
    step();
    start = 1'b0;
    send(8'd200);
    send(8'd100);
    chk("sat_sum8",  32'(sum8), 255);
    chk("sat_ovf8",  32'(ovf8), 1);
    chk("sat_sum16", 32'(sum16), 300);
    chk("sat_ovf16", 32'(ovf16), 0);
    // Consume and restart in the same cycle; ovf must clear for the new block.
    start = 1'b1; len = 4'd1;
    step();
    start = 1'b0;
    chk("sat_restart_ready", 32'(rdy8), 1);
    chk("sat_restart_ovf8",  32'(ovf8), 0);
    send(8'd5);
    chk("sat_next_sum8",  32'(sum8), 5);
    chk("sat_next_ovf8",  32'(ovf8), 0);
    chk("sat_next_sum16", 32'(sum16), 5);
    step();

    // Result held with sum_ready low; start and prod_valid must be ignored.
    sum_ready = 1'b0;
    start = 1'b1; len = 4'd2;
    step();
    start = 1'b0;
    send(8'd7);
    send(8'd8);
    for (int i = 0; i < 5; i++) begin
      start      = (i == 1 || i == 3);
      len        = 4'd5;
      prod_valid = 1'b1;
      prod_in    = 8'd99;
      step();
      chk("hold_valid", 32'(sv16), 1);
      chk("hold_sum",   32'(sum16), 15);
      chk("hold_ready", 32'(rdy16), 0);
    end
    prod_valid = 1'b0;
    sum_ready = 1'b1;
    start = 1'b1; len = 4'd2;
    step();
    start = 1'b0;
    chk("hs_busy",  32'(busy16), 1);
    chk("hs_ready", 32'(rdy16), 1);
    chk("hs_valid", 32'(sv16), 0);
    chk("hs_sum_retained", 32'(sum16), 15);
    send(8'd4);
    send(8'd6);
    chk("hs_sum_from_zero", 32'(sum16), 10);
    step();

    // Reset mid-block discards the partial sum.
    start = 1'b1; len = 4'd4;
    step();
    start = 1'b0;
    send(8'd1);
    send(8'd2);
    reset = 1'b0;
    step();
    chk("mid_rst_busy",  32'(busy16), 0);
    chk("mid_rst_valid", 32'(sv16), 0);
    chk("mid_rst_sum",   32'(sum16), 0);
    chk("mid_rst_ovf",   32'(ovf16), 0);
    chk("mid_rst_ready", 32'(rdy16), 0);
    reset = 1'b1;

    // Products offered in IDLE must not be taken.
    prod_valid = 1'b1;
    prod_in    = 8'd50;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_ready", 32'(rdy16), 0);
      chk("idle_busy",  32'(busy16), 0);
    end
    prod_valid = 1'b0;
    start = 1'b1; len = 4'd1;
    step();
    start = 1'b0;
    send(8'd9);
    chk("post_rst_sum",   32'(sum16), 9);
    chk("post_rst_valid", 32'(sv16), 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
